// File: rtl/mod5167_pkg.sv
// Shared constants for the mod-5167 partial-sum combine path.
// All reduction constants are derived from Q.
package mod5167_pkg;

  localparam int unsigned Q    = 5167;
  localparam int unsigned Q2   = 2 * Q;
  localparam int unsigned Q4   = 4 * Q;
  localparam int unsigned QOFF = 5 * Q;

  localparam int unsigned PW = 13;
  localparam int unsigned NW = 15;
  localparam int unsigned SW = 16;
  localparam int unsigned RW = 13;

endpackage

// File: rtl/mod5167_csub.sv
// Conditional subtract: y = (x >= K) ? x - K : x.
module mod5167_csub #(
  parameter int unsigned SW = 16,
  parameter int unsigned K  = 5167
) (
  input  logic [SW-1:0] x,
  output logic [SW-1:0] y
);

  localparam logic [SW-1:0] KV = SW'(K);

  always_comb begin
    y = x;
    if (x >= KV) begin
      y = x - KV;
    end
  end

endmodule

// File: rtl/mod5167_svec_combine.sv
// Three-stage valid/ready pipeline computing (p0 + p1 - n0 - n1 - n2 - n3) mod Q,
// carrying an opaque tag alongside each result. Global stall on output back-pressure.
module mod5167_svec_combine
  import mod5167_pkg::*;
#(
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAGW-1:0] in_tag,
  input  logic [11:0]     p0,
  input  logic [11:0]     p1,
  input  logic [11:0]     n0,
  input  logic [12:0]     n1,
  input  logic [11:0]     n2,
  input  logic [12:0]     n3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [RW-1:0]   r
);

  logic            adv;
  logic            v1_q, v2_q, v3_q;
  logic [TAGW-1:0] tag1_q, tag2_q, tag3_q;
  logic [PW-1:0]   p_q;
  logic [NW-1:0]   n_q;
  logic [SW-1:0]   s_q;
  logic [RW-1:0]   r_q;

  logic [PW-1:0]   p_sum;
  logic [NW-1:0]   n_sum;
  logic [SW-1:0]   s_sum;
  logic [SW-1:0]   c4, c2, c1;

  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_tag   = tag3_q;
  assign r         = r_q;

  assign p_sum = PW'(p0) + PW'(p1);
  assign n_sum = NW'(n0) + NW'(n1) + NW'(n2) + NW'(n3);
  // Offset by 5*Q so the difference stays positive for every legal input.
  assign s_sum = SW'(p_q) + SW'(QOFF) - SW'(n_q);

  mod5167_csub #(.SW(SW), .K(Q4)) u_csub4 (.x(s_q), .y(c4));
  mod5167_csub #(.SW(SW), .K(Q2)) u_csub2 (.x(c4),  .y(c2));
  mod5167_csub #(.SW(SW), .K(Q))  u_csub1 (.x(c2),  .y(c1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      p_q    <= '0;
      n_q    <= '0;
      s_q    <= '0;
      r_q    <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      tag1_q <= in_tag;
      p_q    <= p_sum;
      n_q    <= n_sum;
      v2_q   <= v1_q;
      tag2_q <= tag1_q;
      s_q    <= s_sum;
      v3_q   <= v2_q;
      tag3_q <= tag2_q;
      r_q    <= RW'(c1);
    end
  end

endmodule
